// File: rtl/uart_tx_sched_if.sv
// Requester handshakes and serial-transmitter control for the UART TX scheduler.
interface uart_tx_sched_if;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_last;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_last;
    logic       req1_ready;
    logic [7:0] tx_data_o;
    logic       tx_start_o;
    logic       tx_busy_i;
    logic [1:0] grant_o;
    logic       err_tmo_o;

    // Requesters and transmitter side
    modport master (
        output req0_valid, req0_data, req0_last,
        output req1_valid, req1_data, req1_last,
        output tx_busy_i,
        input  req0_ready, req1_ready,
        input  tx_data_o, tx_start_o, grant_o, err_tmo_o
    );

    // Scheduler side
    modport slave (
        input  req0_valid, req0_data, req0_last,
        input  req1_valid, req1_data, req1_last,
        input  tx_busy_i,
        output req0_ready, req1_ready,
        output tx_data_o, tx_start_o, grant_o, err_tmo_o
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Two-requester packet scheduler feeding one serial transmitter: round-robin
// per packet, one byte in flight, start-ack timeout and inter-byte gap.
module uart_tx_sched #(
    parameter int unsigned GAP_CYC   = 16,
    parameter int unsigned START_TMO = 8
) (
    input logic             clk,
    input logic             rst_n,
    uart_tx_sched_if.slave  bus
);

    localparam int unsigned CNT_MAX = (GAP_CYC > START_TMO) ? GAP_CYC : START_TMO;
    localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ACCEPT    = 3'd1,
        START     = 3'd2,
        WAIT_ACK  = 3'd3,
        WAIT_DONE = 3'd4,
        GAP       = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic             ptr_q, ptr_d;
    logic             err_q, err_d;
    logic [7:0]       data_q;
    logic             last_q;
    logic             start_q;
    logic [CNT_W-1:0] cnt_q;

    logic [CNT_W:0]   cnt_inc_c;
    logic             gap_done_c;
    logic             tmo_c;
    logic             own_valid_c;
    logic [7:0]       own_data_c;
    logic             own_last_c;
    logic             transfer_c;

    // Owner-side mux; grant is one-hot or zero
    assign own_valid_c = (grant_q[0] & bus.req0_valid) | (grant_q[1] & bus.req1_valid);
    assign own_data_c  = grant_q[1] ? bus.req1_data : bus.req0_data;
    assign own_last_c  = grant_q[1] ? bus.req1_last : bus.req0_last;
    assign transfer_c  = (state_q == ACCEPT) && own_valid_c;

    assign cnt_inc_c  = {1'b0, cnt_q} + (CNT_W + 1)'(1);
    assign gap_done_c = 32'(cnt_inc_c) >= GAP_CYC;
    assign tmo_c      = 32'(cnt_inc_c) >= START_TMO;

    assign bus.req0_ready = (state_q == ACCEPT) && grant_q[0];
    assign bus.req1_ready = (state_q == ACCEPT) && grant_q[1];
    assign bus.tx_data_o  = data_q;
    assign bus.tx_start_o = start_q;
    assign bus.grant_o    = grant_q;
    assign bus.err_tmo_o  = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            ptr_q   <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= 8'h00;
            last_q  <= 1'b0;
            start_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
            start_q <= transfer_c;
            if (transfer_c) begin
                data_q <= own_data_c;
                last_q <= own_last_c;
            end
            // Counter restarts on every state entry; only timed states advance it
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (state_q == WAIT_ACK || state_q == GAP) begin
                cnt_q <= cnt_inc_c[CNT_W-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.req0_valid || bus.req1_valid) begin
                    state_d = ACCEPT;
                    if (bus.req0_valid && bus.req1_valid) begin
                        grant_d = ptr_q ? 2'b10 : 2'b01;
                    end else if (bus.req0_valid) begin
                        grant_d = 2'b01;
                    end else begin
                        grant_d = 2'b10;
                    end
                end
            end
            ACCEPT: begin
                if (transfer_c) begin
                    state_d = START;
                end
            end
            START: begin
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (bus.tx_busy_i) begin
                    state_d = WAIT_DONE;
                end else if (tmo_c) begin
                    err_d   = 1'b1;
                    state_d = GAP;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy_i) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (gap_done_c) begin
                    if (last_q) begin
                        // Packet released: pointer goes to the requester that did not own it
                        grant_d = 2'b00;
                        ptr_d   = grant_q[0];
                        state_d = IDLE;
                    end else begin
                        state_d = ACCEPT;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a simple transmitter busy model.
module tb_uart_tx_sched;

    localparam int unsigned GAP = 16;
    localparam int unsigned TMO = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    bit   model_en = 1'b1;
    int   busy_len = 10;
    logic [7:0] sent_q[$];

    uart_tx_sched_if bus();

    uart_tx_sched #(.GAP_CYC(GAP), .START_TMO(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Captures every start pulse with the byte presented to the transmitter
    initial begin
        forever begin
            @(negedge clk);
            if (bus.tx_start_o === 1'b1) sent_q.push_back(bus.tx_data_o);
        end
    end

    // Transmitter: busy rises two cycles after start and holds for busy_len cycles
    initial begin
        bus.tx_busy_i = 1'b0;
        forever begin
            @(negedge clk);
            if (model_en && bus.tx_start_o === 1'b1) begin
                repeat (2) @(negedge clk);
                bus.tx_busy_i = 1'b1;
                repeat (busy_len) @(negedge clk);
                bus.tx_busy_i = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs;
        bus.req0_valid = 1'b0; bus.req0_data = 8'h00; bus.req0_last = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_data = 8'h00; bus.req1_last = 1'b0;
    endtask

    task automatic apply_reset;
        clear_reqs();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        sent_q.delete();
    endtask

    task automatic wait_ready(input int who, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if ((who == 0 ? bus.req0_ready : bus.req1_ready) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_idle(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (bus.grant_o === 2'b00) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset;
        logic [7:0] exp_q[$];
        bit ok;
        clear_reqs();
        bus.req0_valid = 1'b1;
        rst_n = 1'b0;
        repeat (2) tick();
        checks++; if (bus.grant_o !== 2'b00) begin failures++; $display("FAIL reset_grant got=%b exp=00", bus.grant_o); end
        checks++; if (bus.req0_ready !== 1'b0) begin failures++; $display("FAIL reset_ready0 got=%b exp=0", bus.req0_ready); end
        checks++; if (bus.req1_ready !== 1'b0) begin failures++; $display("FAIL reset_ready1 got=%b exp=0", bus.req1_ready); end
        checks++; if (bus.tx_start_o !== 1'b0) begin failures++; $display("FAIL reset_start got=%b exp=0", bus.tx_start_o); end
        checks++; if (bus.tx_data_o !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", bus.tx_data_o); end
        checks++; if (bus.err_tmo_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.err_tmo_o); end
        bus.req0_valid = 1'b0;
        rst_n = 1'b1;
        repeat (3) tick();
        checks++; if (bus.grant_o !== 2'b00) begin failures++; $display("FAIL idle_grant got=%b exp=00", bus.grant_o); end
        exp_q = {};
        ok = (sent_q.size() == 0);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL idle_no_start got=%0d starts exp=0", sent_q.size()); end
    endtask

    task automatic test_single_byte;
        bit ok;
        int extra = 0;
        int r1 = 0;
        apply_reset();
        busy_len = 100;
        bus.req0_data = 8'hA5; bus.req0_last = 1'b1; bus.req0_valid = 1'b1;
        wait_ready(0, 10, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL single_ready got=timeout exp=ready"); end
        checks++; if (bus.grant_o !== 2'b01) begin failures++; $display("FAIL single_grant got=%b exp=01", bus.grant_o); end
        tick();
        bus.req0_valid = 1'b0;
        checks++; if (bus.tx_start_o !== 1'b1) begin failures++; $display("FAIL single_start got=%b exp=1", bus.tx_start_o); end
        checks++; if (bus.tx_data_o !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", bus.tx_data_o); end
        // start at offset 0; busy sampled 2..101; WAIT_DONE exits at 102; gap 103..118
        for (int k = 1; k <= busy_len + GAP + 3; k++) begin
            tick();
            if (bus.tx_start_o === 1'b1) extra++;
            if (bus.req1_ready === 1'b1) r1++;
            if (k == busy_len + GAP + 2) begin
                checks++; if (bus.grant_o !== 2'b01) begin failures++; $display("FAIL single_gap_hold got=%b exp=01", bus.grant_o); end
            end
            if (k == busy_len + GAP + 3) begin
                checks++; if (bus.grant_o !== 2'b00) begin failures++; $display("FAIL single_release got=%b exp=00", bus.grant_o); end
            end
        end
        checks++; if (extra !== 0) begin failures++; $display("FAIL single_extra_start got=%0d exp=0", extra); end
        checks++; if (r1 !== 0) begin failures++; $display("FAIL single_ready1 got=%0d exp=0", r1); end
        checks++; if (bus.tx_data_o !== 8'hA5) begin failures++; $display("FAIL single_data_hold got=%h exp=a5", bus.tx_data_o); end
        busy_len = 10;
    endtask

    task automatic test_contention;
        bit ok;
        logic [7:0] exp_q[$];
        logic [7:0] got;
        apply_reset();
        bus.req0_data = 8'h10; bus.req0_last = 1'b1; bus.req0_valid = 1'b1;
        bus.req1_data = 8'h20; bus.req1_last = 1'b1; bus.req1_valid = 1'b1;
        wait_ready(0, 10, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL cont_first_ready got=timeout exp=ready0"); end
        checks++; if (bus.req1_ready !== 1'b0) begin failures++; $display("FAIL cont_ready1_low got=%b exp=0", bus.req1_ready); end
        checks++; if (bus.grant_o !== 2'b01) begin failures++; $display("FAIL cont_grant0 got=%b exp=01", bus.grant_o); end
        tick();
        // req0 immediately offers a new packet; pointer now favours req1
        bus.req0_data = 8'h11;
        wait_ready(1, 200, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL cont_second_ready got=timeout exp=ready1"); end
        checks++; if (bus.grant_o !== 2'b10) begin failures++; $display("FAIL cont_grant1 got=%b exp=10", bus.grant_o); end
        tick();
        bus.req1_valid = 1'b0;
        wait_ready(0, 200, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL cont_third_ready got=timeout exp=ready0"); end
        tick();
        bus.req0_valid = 1'b0;
        wait_idle(200, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL cont_idle got=timeout exp=idle"); end
        exp_q = {8'h10, 8'h20, 8'h11};
        for (int i = 0; i < 3; i++) begin
            got = (i < sent_q.size()) ? sent_q[i] : 8'hxx;
            checks++; if (got !== exp_q[i]) begin failures++; $display("FAIL cont_order[%0d] got=%h exp=%h", i, got, exp_q[i]); end
        end
    endtask

    task automatic test_packet_lock;
        bit ok;
        bit r1_seen = 1'b0;
        bit saw_idle = 1'b0;
        logic [7:0] bytes_q[$];
        logic [7:0] exp_q[$];
        logic [7:0] got;
        apply_reset();
        bytes_q = {8'h11, 8'h22, 8'h33};
        bus.req1_data = 8'h44; bus.req1_last = 1'b1; bus.req1_valid = 1'b1;
        bus.req0_valid = 1'b1;
        for (int b = 0; b < 3; b++) begin
            bus.req0_data = bytes_q[b];
            bus.req0_last = (b == 2);
            ok = 1'b0;
            for (int i = 0; i < 200; i++) begin
                if (bus.req1_ready === 1'b1) r1_seen = 1'b1;
                if (bus.req0_ready === 1'b1) begin ok = 1'b1; break; end
                tick();
            end
            checks++; if (ok !== 1'b1) begin failures++; $display("FAIL lock_ready0[%0d] got=timeout exp=ready", b); end
            tick();
        end
        bus.req0_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.grant_o === 2'b00) saw_idle = 1'b1;
            if (bus.req1_ready === 1'b1) begin ok = 1'b1; break; end
            tick();
        end
        checks++; if (r1_seen !== 1'b0) begin failures++; $display("FAIL lock_ready1_early got=1 exp=0"); end
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL lock_ready1 got=timeout exp=ready"); end
        checks++; if (saw_idle !== 1'b1) begin failures++; $display("FAIL lock_release got=no_idle exp=idle_before_req1"); end
        tick();
        bus.req1_valid = 1'b0;
        wait_idle(200, ok);
        exp_q = {8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            got = (i < sent_q.size()) ? sent_q[i] : 8'hxx;
            checks++; if (got !== exp_q[i]) begin failures++; $display("FAIL lock_order[%0d] got=%h exp=%h", i, got, exp_q[i]); end
        end
    endtask

    task automatic test_owner_stall;
        bit ok;
        int r1 = 0;
        int starts = 0;
        int bad_grant = 0;
        logic [7:0] exp_q[$];
        logic [7:0] got;
        apply_reset();
        bus.req0_data = 8'h55; bus.req0_last = 1'b0; bus.req0_valid = 1'b1;
        bus.req1_data = 8'h66; bus.req1_last = 1'b1; bus.req1_valid = 1'b1;
        wait_ready(0, 10, ok);
        tick();
        bus.req0_valid = 1'b0;
        tick();
        wait_ready(0, 200, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL stall_reaccept got=timeout exp=ready0"); end
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bus.req1_ready === 1'b1) r1++;
            if (bus.tx_start_o === 1'b1) starts++;
            if (bus.grant_o !== 2'b01) bad_grant++;
        end
        checks++; if (r1 !== 0) begin failures++; $display("FAIL stall_ready1 got=%0d exp=0", r1); end
        checks++; if (starts !== 0) begin failures++; $display("FAIL stall_start got=%0d exp=0", starts); end
        checks++; if (bad_grant !== 0) begin failures++; $display("FAIL stall_grant got=%0d_bad_cycles exp=0", bad_grant); end
        checks++; if (bus.req0_ready !== 1'b1) begin failures++; $display("FAIL stall_ready0 got=%b exp=1", bus.req0_ready); end
        bus.req0_data = 8'h77; bus.req0_last = 1'b1; bus.req0_valid = 1'b1;
        tick();
        bus.req0_valid = 1'b0;
        wait_ready(1, 200, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL stall_req1_served got=timeout exp=ready1"); end
        tick();
        bus.req1_valid = 1'b0;
        wait_idle(200, ok);
        exp_q = {8'h55, 8'h77, 8'h66};
        for (int i = 0; i < 3; i++) begin
            got = (i < sent_q.size()) ? sent_q[i] : 8'hxx;
            checks++; if (got !== exp_q[i]) begin failures++; $display("FAIL stall_order[%0d] got=%h exp=%h", i, got, exp_q[i]); end
        end
    endtask

    task automatic test_timeout;
        bit ok;
        apply_reset();
        model_en = 1'b0;
        bus.req0_data = 8'h99; bus.req0_last = 1'b1; bus.req0_valid = 1'b1;
        wait_ready(0, 10, ok);
        tick();
        bus.req0_valid = 1'b0;
        checks++; if (bus.tx_start_o !== 1'b1) begin failures++; $display("FAIL tmo_start got=%b exp=1", bus.tx_start_o); end
        for (int k = 1; k <= int'(TMO + GAP + 1); k++) begin
            tick();
            if (k == int'(TMO) - 1) begin
                checks++; if (bus.err_tmo_o !== 1'b0) begin failures++; $display("FAIL tmo_err_early got=%b exp=0", bus.err_tmo_o); end
            end
            if (k == int'(TMO) + 1) begin
                checks++; if (bus.err_tmo_o !== 1'b1) begin failures++; $display("FAIL tmo_err_set got=%b exp=1", bus.err_tmo_o); end
            end
            if (k == int'(TMO + GAP) - 1) begin
                checks++; if (bus.grant_o !== 2'b01) begin failures++; $display("FAIL tmo_gap_hold got=%b exp=01", bus.grant_o); end
            end
            if (k == int'(TMO + GAP) + 1) begin
                checks++; if (bus.grant_o !== 2'b00) begin failures++; $display("FAIL tmo_release got=%b exp=00", bus.grant_o); end
            end
        end
        model_en = 1'b1;
        bus.req1_data = 8'hBB; bus.req1_last = 1'b1; bus.req1_valid = 1'b1;
        wait_ready(1, 20, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL tmo_next_ready got=timeout exp=ready1"); end
        tick();
        bus.req1_valid = 1'b0;
        wait_idle(200, ok);
        checks++; if (bus.err_tmo_o !== 1'b1) begin failures++; $display("FAIL tmo_sticky got=%b exp=1", bus.err_tmo_o); end
        checks++; if (sent_q.size() !== 2) begin failures++; $display("FAIL tmo_bytes got=%0d exp=2", sent_q.size()); end
    endtask

    task automatic test_reset_wait_done;
        bit ok;
        logic [7:0] exp_q[$];
        logic [7:0] got;
        apply_reset();
        bus.req0_data = 8'hC3; bus.req0_last = 1'b1; bus.req0_valid = 1'b1;
        wait_ready(0, 10, ok);
        tick();
        bus.req0_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.tx_busy_i === 1'b1) begin ok = 1'b1; break; end
            tick();
        end
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rwd_busy got=timeout exp=busy"); end
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        checks++; if (bus.grant_o !== 2'b00) begin failures++; $display("FAIL rwd_grant got=%b exp=00", bus.grant_o); end
        checks++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin failures++; $display("FAIL rwd_ready got=%b%b exp=00", bus.req1_ready, bus.req0_ready); end
        checks++; if (bus.tx_start_o !== 1'b0) begin failures++; $display("FAIL rwd_start got=%b exp=0", bus.tx_start_o); end
        checks++; if (bus.tx_data_o !== 8'h00) begin failures++; $display("FAIL rwd_data got=%h exp=00", bus.tx_data_o); end
        checks++; if (bus.err_tmo_o !== 1'b0) begin failures++; $display("FAIL rwd_err got=%b exp=0", bus.err_tmo_o); end
        repeat (2) tick();
        rst_n = 1'b1;
        sent_q.delete();
        for (int i = 0; i < 30; i++) begin
            if (bus.tx_busy_i === 1'b0) break;
            tick();
        end
        bus.req0_data = 8'h3C; bus.req0_last = 1'b1; bus.req0_valid = 1'b1;
        bus.req1_data = 8'h5A; bus.req1_last = 1'b1; bus.req1_valid = 1'b1;
        wait_ready(0, 10, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rwd_req0_first got=timeout exp=ready0"); end
        tick();
        bus.req0_valid = 1'b0;
        wait_ready(1, 200, ok);
        tick();
        bus.req1_valid = 1'b0;
        wait_idle(200, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rwd_idle got=timeout exp=idle"); end
        exp_q = {8'h3C, 8'h5A};
        checks++; if (sent_q.size() !== 2) begin failures++; $display("FAIL rwd_count got=%0d exp=2", sent_q.size()); end
        for (int i = 0; i < 2; i++) begin
            got = (i < sent_q.size()) ? sent_q[i] : 8'hxx;
            checks++; if (got !== exp_q[i]) begin failures++; $display("FAIL rwd_order[%0d] got=%h exp=%h", i, got, exp_q[i]); end
        end
    endtask

    initial begin
        clear_reqs();
        rst_n = 1'b0;
        test_reset();
        test_single_byte();
        test_contention();
        test_packet_lock();
        test_owner_stall();
        test_timeout();
        test_reset_wait_done();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter GAP_CYC, default 16: idle clk cycles inserted after each byte completes before the next accept.
REQ-002 Parameter START_TMO, default 8: max clk cycles after tx_start_o to wait for tx_busy_i to rise.
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req0_valid  input  1  requester 0 has a byte on req0_data.
REQ-006 req0_data  input  8  requester 0 byte.
REQ-007 req0_last  input  1  byte is final byte of requester 0 packet; sampled with the byte.
REQ-008 req0_ready  output  1  scheduler accepts requester 0 byte this cycle.
REQ-009 req1_valid, req1_data[8], req1_last, req1_ready: same as REQ-005..008 for requester 1.
REQ-010 tx_data_o  output  8  byte driven to serial transmitter data input.
REQ-011 tx_start_o  output  1  one-cycle start pulse to serial transmitter.
REQ-012 tx_busy_i  input  1  transmitter busy (high from start until stop bit done).
REQ-013 grant_o  output  2  one-hot current packet owner; 2'b00 when idle.
REQ-014 err_tmo_o  output  1  sticky flag: transmitter failed to go busy within START_TMO.

Function
REQ-015 States: IDLE, ACCEPT, START, WAIT_ACK, WAIT_DONE, GAP.
REQ-016 IDLE: if any valid, next state ACCEPT with grant_o set to chosen requester; else stay.
REQ-017 Arbitration: round-robin pointer; both valid -> pointer requester wins; one valid -> that one wins regardless of pointer.
REQ-018 Pointer moves to the other requester only when a packet is released (last byte done); reset value points to requester 0.
REQ-019 reqN_ready = (state==ACCEPT) && grant_o[N]; combinational; never high for the non-granted requester.
REQ-020 Transfer occurs on a cycle with reqN_valid && reqN_ready; byte and last flag latched; next state START.
REQ-021 ACCEPT with owner valid low: hold state and grant indefinitely (packet lock); other requester not served.
REQ-022 START: tx_start_o high exactly one cycle (cycle after transfer); tx_data_o already equal to accepted byte; next WAIT_ACK.
REQ-023 tx_data_o updated only on transfer; held stable otherwise.
REQ-024 WAIT_ACK: tx_busy_i high -> WAIT_DONE; counter reaching START_TMO cycles without busy -> set err_tmo_o, go GAP.
REQ-025 WAIT_DONE: tx_busy_i low -> GAP.
REQ-026 GAP: count GAP_CYC cycles (GAP_CYC=0 -> single pass-through cycle); then latched last=1 -> grant_o=0, pointer to other requester, IDLE; last=0 -> ACCEPT, same owner.
REQ-027 Timeout byte treated as sent for packet sequencing (last flag still honoured).
REQ-028 err_tmo_o cleared only by reset.
REQ-029 tx_busy_i changes outside WAIT_ACK/WAIT_DONE ignored.
REQ-030 Counters sized to hold max(GAP_CYC, START_TMO) without wrap; reset to 0 on each state entry.
REQ-031 Minimum per-byte cost: 1 accept + 1 start + ack + serial time + GAP_CYC cycles.

Reset
REQ-032 rst_n low, any state: state IDLE, grant_o=0, req0_ready=req1_ready=0, tx_start_o=0, tx_data_o=8'h00, err_tmo_o=0, pointer=requester 0, counters 0, latched last=0.
REQ-033 Reset mid-packet aborts the packet; no tx_start_o until a fresh transfer after release.

Verification
REQ-034 Single byte: req0 valid 8'hA5 last=1, transmitter model busy 2 cycles after start for 100 cycles -> one tx_start_o pulse, tx_data_o=8'hA5, grant_o 01 then 00 after GAP_CYC.
REQ-035 Contention: req0 and req1 valid (last=1) same cycle after reset -> req0 served first, then req1; next simultaneous request -> req1 first.
REQ-036 Packet lock: req0 sends 3 bytes (last on 3rd) with req1 valid throughout -> req1_ready stays 0 until req0 byte 3 gap ends; bytes out 11,22,33 in order.
REQ-037 Owner stall: req0 byte 1 last=0, then valid low 50 cycles while req1 valid -> grant_o stays 01, no tx_start_o, req1_ready 0.
REQ-038 Timeout: tx_busy_i tied low -> err_tmo_o high START_TMO cycles after tx_start_o, FSM returns to IDLE after GAP_CYC, flag stays high.
REQ-039 Reset in WAIT_DONE -> all outputs at REQ-032 values on assertion; after release, new request served normally from requester 0.
